// File: rtl/spi_clgen_pkg.sv
// Shared constants for the SPI master: divider width and divider reset value.
// The control register block and shift register use the same constants.
package spi_clgen_pkg;

   // Divider width; legal values are 8, 16, 24 and 32.
   localparam int unsigned SpiDividerLen = 16;

   // Divider register value after reset (slowest serial clock).
   localparam logic [SpiDividerLen-1:0] SpiDividerRst = '1;

   // Counter and divider decodes used by the clock generator.
   typedef struct packed {
      logic cnt_zero;
      logic cnt_one;
      logic div_zero;
   } clgen_dec_t;

endpackage : spi_clgen_pkg

// File: rtl/spi_clgen.sv
// SPI serial-clock generator: divides wb_clk_in by 2*(divider+1) while a
// transfer is in progress and strobes cpol_0/cpol_1 one cycle ahead of each
// rising/falling sclk_out edge.
module spi_clgen
   import spi_clgen_pkg::*;
#(
   parameter int unsigned DIVIDER_LEN = SpiDividerLen
) (
   input  logic                   wb_clk_in,
   input  logic                   wb_rst,
   input  logic                   go,
   input  logic                   tip,
   input  logic                   last_clk,
   input  logic [DIVIDER_LEN-1:0] divider,
   output logic                   sclk_out,
   output logic                   cpol_0,
   output logic                   cpol_1
);

   logic [DIVIDER_LEN-1:0] cnt_q, cnt_d;
   logic                   sclk_q, sclk_d;
   logic                   cpol_0_q, cpol_0_d;
   logic                   cpol_1_q, cpol_1_d;
   clgen_dec_t             dec;

   // Decode counter and divider states.
   always_comb begin
      dec          = '0;
      dec.cnt_zero = (cnt_q == '0);
      dec.cnt_one  = (cnt_q == DIVIDER_LEN'(1));
      dec.div_zero = (divider == '0);
   end

   // Next-state for counter, serial clock and edge strobes.
   always_comb begin
      cnt_d    = cnt_q;
      sclk_d   = sclk_q;
      cpol_0_d = 1'b0;
      cpol_1_d = 1'b0;

      // While idle the counter keeps reloading so divider changes apply at once.
      if (!tip || dec.cnt_zero) begin
         cnt_d = divider;
      end else begin
         cnt_d = cnt_q - DIVIDER_LEN'(1);
      end

      // last_clk blocks a further 0->1 edge so the clock parks at idle low.
      if (tip && dec.cnt_zero && (!last_clk || sclk_q)) begin
         sclk_d = ~sclk_q;
      end

      // divider==0 toggles every cycle, so strobes follow sclk level directly;
      // go pre-announces the first rising edge before tip is up.
      cpol_0_d = (tip && !sclk_q && dec.cnt_one) ||
                 (dec.div_zero && sclk_q) ||
                 (dec.div_zero && go && !tip);
      cpol_1_d = (tip && sclk_q && dec.cnt_one) ||
                 (dec.div_zero && !sclk_q && tip);
   end

   // State registers with synchronous active-high reset.
   always_ff @(posedge wb_clk_in) begin
      if (wb_rst) begin
         cnt_q    <= '1;
         sclk_q   <= 1'b0;
         cpol_0_q <= 1'b0;
         cpol_1_q <= 1'b0;
      end else begin
         cnt_q    <= cnt_d;
         sclk_q   <= sclk_d;
         cpol_0_q <= cpol_0_d;
         cpol_1_q <= cpol_1_d;
      end
   end

   assign sclk_out = sclk_q;
   assign cpol_0   = cpol_0_q;
   assign cpol_1   = cpol_1_q;

endmodule : spi_clgen

// File: tb/tb_spi_clgen.sv
// Directed bench for spi_clgen. Each expected output triple is encoded as one
// digit {sclk_out, cpol_0, cpol_1} per wb_clk_in cycle, sampled mid-cycle.
module tb_spi_clgen;

   logic        wb_clk_in = 1'b0;
   logic        wb_rst;
   logic        go;
   logic        tip;
   logic        last_clk;
   logic [15:0] divider;
   logic        sclk_out;
   logic        cpol_0;
   logic        cpol_1;

   int n_cmp  = 0;
   int n_fail = 0;

   spi_clgen #(
      .DIVIDER_LEN(16)
   ) dut (
      .wb_clk_in(wb_clk_in),
      .wb_rst   (wb_rst),
      .go       (go),
      .tip      (tip),
      .last_clk (last_clk),
      .divider  (divider),
      .sclk_out (sclk_out),
      .cpol_0   (cpol_0),
      .cpol_1   (cpol_1)
   );

   always #5 wb_clk_in = ~wb_clk_in;

   // Advance one clock edge per digit and compare outputs mid-cycle.
   task automatic run_seq(input string tag, input string seq);
      logic [2:0] obs;
      logic [2:0] exp;
      for (int i = 0; i < seq.len(); i++) begin
         @(posedge wb_clk_in);
         @(negedge wb_clk_in);
         exp = 3'(seq[i] - 8'd48);
         obs = {sclk_out, cpol_0, cpol_1};
         n_cmp++;
         assert (obs === exp)
         else begin
            n_fail++;
            $error("FAIL %s[%0d] observed {sclk,c0,c1}=%b expected=%b", tag, i, obs, exp);
         end
      end
   endtask

   initial begin
      wb_rst   = 1'b1;
      go       = 1'b0;
      tip      = 1'b0;
      last_clk = 1'b0;
      divider  = 16'd1;

      // Reset, then one idle cycle reloads cnt to 1.
      run_seq("reset", "0");
      wb_rst = 1'b0;
      run_seq("reset_rel", "0");

      // divider=1: go then tip, period 4 cycles.
      go = 1'b1;
      run_seq("div1_go", "0");
      go  = 1'b0;
      tip = 1'b1;
      run_seq("div1_run", "24502450");

      // divider=3: half-period 4, period 8.
      tip     = 1'b0;
      divider = 16'd3;
      run_seq("div3_idle", "0");
      tip = 1'b1;
      run_seq("div3_run", "0024445000244450");

      // divider=0: go pre-issues cpol_0, then toggling every cycle.
      tip     = 1'b0;
      divider = 16'd0;
      go      = 1'b1;
      run_seq("div0_go", "2");
      go  = 1'b0;
      tip = 1'b1;
      run_seq("div0_run", "525252");
      tip = 1'b0;
      run_seq("div0_stop", "0");

      // last_clk raised while sclk high: one fall, then parked low.
      divider = 16'd1;
      run_seq("last_idle", "0");
      tip = 1'b1;
      run_seq("last_pre", "24");
      last_clk = 1'b1;
      run_seq("last_park", "50202020202020");

      // Mid-transfer reset with sclk high.
      last_clk = 1'b0;
      run_seq("rst_pre", "24");
      wb_rst = 1'b1;
      run_seq("rst_mid", "00");
      wb_rst = 1'b0;
      tip    = 1'b0;
      run_seq("rst_reload", "0");
      tip = 1'b1;
      run_seq("rst_resume", "2450");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule : tb_spi_clgen
